// File: rtl/exe_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : exe_mem_pipe_reg
//  Brief    : EX->MEM pipeline register with valid/ready handshake, a
//             two-entry skid buffer and a synchronous flush. The upstream
//             ready depends only on registered state, never on out_ready.
//  Revision : 1.0  initial release
// ============================================================================
module exe_mem_pipe_reg #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] alu_res_in,
    input  logic [ADDR_W-1:0] val_rm_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic              mem_w_en_in,
    input  logic              mem_r_en_in,
    input  logic              wb_en_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] alu_res,
    output logic [ADDR_W-1:0] val_rm,
    output logic [REG_W-1:0]  dest,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic              wb_en,
    output logic [1:0]        occupancy
);

    // One stored entry: {pc, alu_res, val_rm, dest, mem_w_en, mem_r_en, wb_en}
    localparam int C_ENT_W = 3*ADDR_W + REG_W + 3;

    // State encoding equals the number of held entries
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_ENT_W-1:0]   r_main;
    logic [C_ENT_W-1:0]   r_skid;
    logic [C_ENT_W-1:0]   w_in_ent;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_load_main_in;
    logic                 w_load_main_skid;
    logic                 w_load_skid_in;

    assign w_in_ent    = {pc_in, alu_res_in, val_rm_in, dest_in,
                          mem_w_en_in, mem_r_en_in, wb_en_in};

    // rst is folded in so in_ready is low for the whole reset window
    assign w_in_ready  = rst & (r_state != S_TWO);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_accept    = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and data-movement decode; flush overrides everything
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = S_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt    = S_TWO;
                    w_load_skid_in = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt    = S_EMPTY;
                end
            end
            S_TWO: begin
                // No accept is possible here; the older main entry leaves first
                if (w_pop) begin
                    w_state_nxt      = S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
        if (flush) begin
            // Squash held entries and drop the same-cycle input
            w_state_nxt      = S_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid_in   = 1'b0;
        end
    end

    // Entry storage; contents persist after the slot empties
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in_ent;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid_in) begin
                r_skid <= w_in_ent;
            end
        end
    end

    // Head entry drives the MEM side; side-effect controls gated by validity
    assign pc        = r_main[C_ENT_W-1          -: ADDR_W];
    assign alu_res   = r_main[C_ENT_W-1-ADDR_W   -: ADDR_W];
    assign val_rm    = r_main[C_ENT_W-1-2*ADDR_W -: ADDR_W];
    assign dest      = r_main[REG_W+2 : 3];
    assign mem_w_en  = r_main[2] & w_out_valid;
    assign mem_r_en  = r_main[1] & w_out_valid;
    assign wb_en     = r_main[0] & w_out_valid;
    assign out_valid = w_out_valid;
    assign in_ready  = w_in_ready;
    assign occupancy = r_state;

endmodule
`default_nettype wire

// File: tb/tb_exe_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_mem_pipe_reg
//  Brief    : Directed self-checking bench for exe_mem_pipe_reg.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exe_mem_pipe_reg;

    localparam int ADDR_W = 32;
    localparam int REG_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] alu_res_in;
    logic [ADDR_W-1:0] val_rm_in;
    logic [REG_W-1:0]  dest_in;
    logic              mem_w_en_in;
    logic              mem_r_en_in;
    logic              wb_en_in;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] alu_res;
    logic [ADDR_W-1:0] val_rm;
    logic [REG_W-1:0]  dest;
    logic              mem_w_en;
    logic              mem_r_en;
    logic              wb_en;
    logic [1:0]        occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    exe_mem_pipe_reg #(.ADDR_W(ADDR_W), .REG_W(REG_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pc_in      (pc_in),
        .alu_res_in (alu_res_in),
        .val_rm_in  (val_rm_in),
        .dest_in    (dest_in),
        .mem_w_en_in(mem_w_en_in),
        .mem_r_en_in(mem_r_en_in),
        .wb_en_in   (wb_en_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pc         (pc),
        .alu_res    (alu_res),
        .val_rm     (val_rm),
        .dest       (dest),
        .mem_w_en   (mem_w_en),
        .mem_r_en   (mem_r_en),
        .wb_en      (wb_en),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an instruction; alu_res and dest derive from pc so they vary too
    task automatic set_in(input logic [31:0] p, input logic [31:0] rm,
                          input logic w, input logic r, input logic wb);
        pc_in       = p;
        alu_res_in  = p + 32'h1000;
        val_rm_in   = rm;
        dest_in     = p[5:2];
        mem_w_en_in = w;
        mem_r_en_in = r;
        wb_en_in    = wb;
    endtask

    // Advance one edge and sample just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_pc", pc, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // Streaming
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_in(32'h00, 32'h11, 1'b0, 1'b1, 1'b1);
        step();
        check("s0_valid", out_valid, 1);
        check("s0_pc", pc, 32'h00);
        check("s0_occ", occupancy, 1);
        check("s0_mem_r", mem_r_en, 1);
        set_in(32'h04, 32'h22, 1'b0, 1'b1, 1'b1);
        step();
        check("s1_pc", pc, 32'h04);
        check("s1_occ", occupancy, 1);
        check("s1_in_ready", in_ready, 1);
        set_in(32'h08, 32'h33, 1'b0, 1'b1, 1'b1);
        step();
        check("s2_pc", pc, 32'h08);
        check("s2_alu", alu_res, 32'h1008);
        check("s2_dest", dest, 4'h2);
        check("s2_val_rm", val_rm, 32'h33);
        in_valid = 1'b0;
        step();
        check("s3_valid", out_valid, 0);
        check("s3_occ", occupancy, 0);
        check("s3_pc_kept", pc, 32'h08);

        // Stall fill
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(32'h10, 32'hAAAA, 1'b1, 1'b0, 1'b1);
        step();
        check("f0_occ", occupancy, 1);
        check("f0_mem_w", mem_w_en, 1);
        set_in(32'h14, 32'hBBBB, 1'b0, 1'b1, 1'b1);
        step();
        check("f1_occ", occupancy, 2);
        check("f1_in_ready", in_ready, 0);
        check("f1_pc", pc, 32'h10);
        set_in(32'h18, 32'hCCCC, 1'b1, 1'b1, 1'b1);
        step();
        check("f2_occ", occupancy, 2);
        check("f2_pc", pc, 32'h10);

        // Drain order
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("d0_occ", occupancy, 1);
        check("d0_pc", pc, 32'h14);
        check("d0_val_rm", val_rm, 32'hBBBB);
        check("d0_mem_w", mem_w_en, 0);
        check("d0_mem_r", mem_r_en, 1);
        step();
        check("d1_valid", out_valid, 0);
        check("d1_mem_w", mem_w_en, 0);
        check("d1_wb", wb_en, 0);
        check("d1_mem_r", mem_r_en, 0);
        check("d1_in_ready", in_ready, 1);

        // Flush from TWO with a simultaneous push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(32'h30, 32'h3030, 1'b0, 1'b0, 1'b1);
        step();
        set_in(32'h34, 32'h3434, 1'b0, 1'b0, 1'b1);
        step();
        check("fl_pre_occ", occupancy, 2);
        flush = 1'b1;
        set_in(32'h20, 32'h2020, 1'b1, 1'b0, 1'b1);
        step();
        check("fl_occ", occupancy, 0);
        check("fl_valid", out_valid, 0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("fl_post_valid", out_valid, 0);
        check("fl_pc_not_20", pc, 32'h30);

        // Async reset mid-operation
        in_valid = 1'b1;
        set_in(32'h40, 32'h4040, 1'b1, 1'b0, 1'b1);
        step();
        set_in(32'h44, 32'h4444, 1'b0, 1'b1, 1'b1);
        step();
        check("ar_pre_occ", occupancy, 2);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_in_ready", in_ready, 0);
        check("ar_occ", occupancy, 0);
        check("ar_pc", pc, 0);
        check("ar_alu", alu_res, 0);
        check("ar_val_rm", val_rm, 0);
        check("ar_dest", dest, 0);
        step();
        check("ar_hold_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        set_in(32'h50, 32'h5050, 1'b0, 1'b0, 1'b1);
        #1;
        check("ar_rel_ready", in_ready, 1);
        check("ar_rel_valid", out_valid, 0);
        step();
        check("ar_first_valid", out_valid, 1);
        check("ar_first_pc", pc, 32'h50);
        check("ar_first_occ", occupancy, 1);

        // Bubble gating
        out_ready = 1'b1;
        set_in(32'h60, 32'hCCCC, 1'b1, 1'b0, 1'b0);
        step();
        check("bg_pc", pc, 32'h60);
        check("bg_mem_w", mem_w_en, 1);
        in_valid = 1'b0;
        step();
        check("bg_valid", out_valid, 0);
        check("bg_mem_w_off", mem_w_en, 0);
        check("bg_val_rm", val_rm, 32'hCCCC);
        step();
        check("bg2_mem_w_off", mem_w_en, 0);
        check("bg2_val_rm", val_rm, 32'hCCCC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
